// File: rtl/pin_capture_pkg.sv
// Shared types for the pin capture writer: FSM state encoding and buffer depth helper.
package pin_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } cap_state_t;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port (read-before-write).
module capture_ram
    import pin_capture_pkg::*;
#(
    parameter int unsigned NUM_BITS = 1,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [NUM_BITS-1:0] wr_data,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [NUM_BITS-1:0] rd_data
);

    localparam int unsigned DEPTH = depth_of(ADDR_W);

    logic [NUM_BITS-1:0] mem [DEPTH];
    logic [NUM_BITS-1:0] rd_data_d;
    logic [NUM_BITS-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = mem[rd_addr];
    end

    // Same-address read/write returns the old word since the array updates after this sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pin_capture_writer.sv
// Registers input pins and writes DEPTH samples into a buffer after arm plus a pin-edge trigger.
// Optional pre-trigger history is enabled by defining PIN_CAPTURE_PRETRIG_EN.
module pin_capture_writer
    import pin_capture_pkg::*;
#(
    parameter int unsigned NUM_BITS    = 1,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned PRE_SAMPLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] pin_in,
    input  logic                arm,
    input  logic [NUM_BITS-1:0] trig_mask,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [NUM_BITS-1:0] rd_data,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     wr_count,
    output logic [ADDR_W-1:0]   trig_pos
);

    localparam int unsigned DEPTH = depth_of(ADDR_W);
    localparam int unsigned CNT_W = ADDR_W + 1;

    if (PRE_SAMPLES >= DEPTH) begin : g_pre_check
        $error("PRE_SAMPLES must be smaller than the buffer depth");
    end

    cap_state_t          state_q, state_d;
    logic [NUM_BITS-1:0] samp_q, samp_d;
    logic [NUM_BITS-1:0] prev_q, prev_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    wr_count_q, wr_count_d;
    logic [ADDR_W-1:0]   trig_pos_q, trig_pos_d;
    logic                settle_q, settle_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                we_c;
    logic                trig_hit_c;

`ifdef PIN_CAPTURE_PRETRIG_EN
    localparam int unsigned POST = DEPTH - PRE_SAMPLES;

    logic [CNT_W-1:0] post_q, post_d;
    logic [CNT_W-1:0] wr_count_sat_c;

    assign wr_count_sat_c = (wr_count_q == CNT_W'(DEPTH)) ? wr_count_q : wr_count_q + CNT_W'(1);
`endif

    assign trig_hit_c = (trig_mask == '0) || (|((samp_q ^ prev_q) & trig_mask));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            samp_q     <= '0;
            prev_q     <= '0;
            wr_ptr_q   <= '0;
            wr_count_q <= '0;
            trig_pos_q <= '0;
            settle_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef PIN_CAPTURE_PRETRIG_EN
            post_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            samp_q     <= samp_d;
            prev_q     <= prev_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_count_q <= wr_count_d;
            trig_pos_q <= trig_pos_d;
            settle_q   <= settle_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef PIN_CAPTURE_PRETRIG_EN
            post_q     <= post_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        samp_d     = pin_in;
        prev_d     = samp_q;
        wr_ptr_d   = wr_ptr_q;
        wr_count_d = wr_count_q;
        trig_pos_d = trig_pos_q;
        settle_d   = 1'b0;
        we_c       = 1'b0;
`ifdef PIN_CAPTURE_PRETRIG_EN
        post_d     = post_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (arm) begin
                    state_d    = ARMED;
                    wr_ptr_d   = '0;
                    wr_count_d = '0;
                    settle_d   = 1'b1;
`ifdef PIN_CAPTURE_PRETRIG_EN
                    post_d     = '0;
`endif
                end
            end
            ARMED: begin
`ifdef PIN_CAPTURE_PRETRIG_EN
                // History keeps rolling; trigger waits until PRE_SAMPLES writes are in the buffer.
                we_c       = 1'b1;
                wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
                wr_count_d = wr_count_sat_c;
                if (!settle_q && trig_hit_c && (wr_count_q >= CNT_W'(PRE_SAMPLES))) begin
                    trig_pos_d = wr_ptr_q;
                    post_d     = CNT_W'(1);
                    state_d    = (POST == 1) ? DONE : CAPTURE;
                end
`else
                if (!settle_q && trig_hit_c) begin
                    we_c       = 1'b1;
                    wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
                    wr_count_d = CNT_W'(1);
                    trig_pos_d = wr_ptr_q;
                    state_d    = CAPTURE;
                end
`endif
            end
            CAPTURE: begin
                we_c     = 1'b1;
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
`ifdef PIN_CAPTURE_PRETRIG_EN
                wr_count_d = wr_count_sat_c;
                post_d     = post_q + CNT_W'(1);
                if (post_d == CNT_W'(POST)) begin
                    state_d = DONE;
                end
`else
                wr_count_d = wr_count_q + CNT_W'(1);
                if (wr_count_d == CNT_W'(DEPTH)) begin
                    state_d = DONE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ARMED) || (state_d == CAPTURE);
        done_d = (state_d == DONE);
    end

    capture_ram #(
        .NUM_BITS (NUM_BITS),
        .ADDR_W   (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (we_c),
        .wr_addr (wr_ptr_q),
        .wr_data (samp_q),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_count = wr_count_q;
    assign trig_pos = trig_pos_q;

endmodule
